// File: rtl/bw_decode_window_pkg.sv
// Shared types and helpers for the BlackWidow decode-window sequencer:
// instruction layout, opcodes, the NOP filler and postfix classification.
package bw_decode_window_pkg;

  localparam int INSN_W    = 32;
  localparam int OPC_W     = 7;
  localparam int WIN_SLOTS = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 7'h00,
    OP_ADD  = 7'h02,
    OP_ADDI = 7'h04,
    OP_LDO  = 7'h10,
    OP_CON1 = 7'h7c,
    OP_CON2 = 7'h7d,
    OP_CON3 = 7'h7e,
    OP_CON4 = 7'h7f
  } opcode_e;

  typedef struct packed {
    logic [INSN_W-OPC_W-1:0] operand;
    logic [OPC_W-1:0]        opcode;
  } insn_t;

  localparam insn_t NOP_INSN = '{operand: '0, opcode: OP_NOP};

  // True for any constant postfix; these never start a decode group.
  function automatic logic is_postfix(logic [OPC_W-1:0] opc);
    return (opc == OP_CON1) || (opc == OP_CON2) ||
           (opc == OP_CON3) || (opc == OP_CON4);
  endfunction

  // Postfix opcode expected in window slot j (1..3). CON4 is never chained.
  function automatic logic [OPC_W-1:0] con_of(int unsigned j);
    case (j)
      1:       return OP_CON1;
      2:       return OP_CON2;
      3:       return OP_CON3;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/bw_insn_fifo.sv
// Instruction FIFO with single push, multi-pop (0..4) and a four-entry
// peek window starting at the head.
module bw_insn_fifo
  import bw_decode_window_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  insn_t                  push_data_i,
  input  logic [2:0]             pop_cnt_i,
  output insn_t                  peek_o [WIN_SLOTS],
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0] head_q, head_d;
  logic [CW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  insn_t         mem_q [DEPTH];

  // Next pointers and occupancy; pointers wrap modulo DEPTH.
  always_comb begin
    // NOTE: defaults first on every path so no latch is inferred.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = {1'b0, AW'(head_q + CW'(pop_cnt_i))};
      tail_d  = {1'b0, AW'(tail_q + CW'(push_i))};
      count_d = count_q + CW'(push_i) - CW'(pop_cnt_i);
    end
  end

  // Peek window: slot j reads entry (head + j) mod DEPTH.
  always_comb begin
    for (int j = 0; j < WIN_SLOTS; j++) begin
      peek_o[j] = mem_q[AW'(head_q + CW'(j))];
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; occupancy is governed by count/pointers,
    // so stale data is never observed and the array maps onto plain RAM.
    if (push_i && !flush_i) begin
      mem_q[tail_q[AW-1:0]] <= push_data_i;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bw_decode_window.sv
// Decode-window sequencer: finds a base instruction plus its trailing
// CON1..CON3 postfixes at the FIFO head, issues them as one registered
// decode group and pops the whole group; stray postfixes are dropped.
module bw_decode_window
  import bw_decode_window_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       fetch_idle_i,
  input  logic       fetch_valid_i,
  input  insn_t      fetch_insn_i,
  output logic       fetch_ready_o,
  output logic       dec_valid_o,
  input  logic       dec_ready_i,
  output insn_t      ir_o,
  output insn_t      ir1_o,
  output insn_t      ir2_o,
  output insn_t      ir3_o,
  output logic [2:0] grp_len_o,
  output logic       orphan_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]        fifo_count;
  insn_t                peek [WIN_SLOTS];
  logic [WIN_SLOTS-1:0] slot_valid;
  logic [WIN_SLOTS-1:0] ext;
  logic [1:0]           chain_len;
  logic                 stop_seen;
  logic                 resolved;
  logic                 head_postfix;
  logic                 out_free;
  logic                 do_issue;
  logic                 do_orphan;
  logic                 push;
  logic [2:0]           pop_cnt;

  insn_t      win_q [WIN_SLOTS];
  insn_t      win_d [WIN_SLOTS];
  logic       dec_valid_q, dec_valid_d;
  logic [2:0] grp_len_q, grp_len_d;
  logic       orphan_q, orphan_d;

  bw_insn_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .push_i      (push),
    .push_data_i (fetch_insn_i),
    .pop_cnt_i   (pop_cnt),
    .peek_o      (peek),
    .count_o     (fifo_count)
  );

  assign fetch_ready_o = (fifo_count < CW'(DEPTH));
  assign push          = fetch_valid_i && fetch_ready_o && !flush_i;

  // Chain detection and issue/orphan decision from FIFO state.
  always_comb begin
    slot_valid = '0;
    for (int j = 0; j < WIN_SLOTS; j++) begin
      slot_valid[j] = (fifo_count > CW'(j));
    end

    // ext[j]: slot j belongs to the group; a valid non-matching slot right
    // after the chain proves the chain cannot grow.
    ext       = '0;
    ext[0]    = 1'b1;
    stop_seen = 1'b0;
    for (int j = 1; j < WIN_SLOTS; j++) begin
      ext[j]    = ext[j-1] && slot_valid[j] && (peek[j].opcode == con_of(j));
      stop_seen = stop_seen || (ext[j-1] && slot_valid[j] && !ext[j]);
    end
    chain_len = 2'(ext[1]) + 2'(ext[2]) + 2'(ext[3]);
    resolved  = stop_seen || ext[3] || fetch_idle_i;

    head_postfix = is_postfix(peek[0].opcode);
    out_free     = !dec_valid_q || dec_ready_i;
    do_issue     = !flush_i && slot_valid[0] && !head_postfix && resolved && out_free;
    do_orphan    = !flush_i && slot_valid[0] && head_postfix;

    if (do_issue) begin
      pop_cnt = {1'b0, chain_len} + 3'd1;
    end else if (do_orphan) begin
      pop_cnt = 3'd1;
    end else begin
      pop_cnt = 3'd0;
    end
  end

  // Next value of the registered decode window.
  always_comb begin
    win_d       = win_q;
    dec_valid_d = dec_valid_q;
    grp_len_d   = grp_len_q;
    orphan_d    = do_orphan;
    if (flush_i) begin
      dec_valid_d = 1'b0;
      grp_len_d   = 3'd0;
      for (int j = 0; j < WIN_SLOTS; j++) begin
        win_d[j] = NOP_INSN;
      end
    end else if (do_issue) begin
      dec_valid_d = 1'b1;
      grp_len_d   = {1'b0, chain_len} + 3'd1;
      win_d[0]    = peek[0];
      // Slots past the chain carry NOP so the decoder never sees an
      // unrelated postfix.
      for (int j = 1; j < WIN_SLOTS; j++) begin
        win_d[j] = ext[j] ? peek[j] : NOP_INSN;
      end
    end else if (dec_ready_i) begin
      dec_valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int j = 0; j < WIN_SLOTS; j++) begin
        win_q[j] <= NOP_INSN;
      end
      dec_valid_q <= 1'b0;
      grp_len_q   <= 3'd0;
      orphan_q    <= 1'b0;
    end else begin
      win_q       <= win_d;
      dec_valid_q <= dec_valid_d;
      grp_len_q   <= grp_len_d;
      orphan_q    <= orphan_d;
    end
  end

  assign ir_o        = win_q[0];
  assign ir1_o       = win_q[1];
  assign ir2_o       = win_q[2];
  assign ir3_o       = win_q[3];
  assign dec_valid_o = dec_valid_q;
  assign grp_len_o   = grp_len_q;
  assign orphan_o    = orphan_q;

endmodule

// File: tb/tb_bw_decode_window.sv
// Scoreboard bench for bw_decode_window: stimulus pushes expected groups,
// a negedge monitor pops and compares on every accepted group.
module tb_bw_decode_window;
  import bw_decode_window_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_i, flush_i, fetch_idle_i, fetch_valid_i, dec_ready_i;
  insn_t      fetch_insn_i;
  logic       fetch_ready_o, dec_valid_o, orphan_o;
  insn_t      ir_o, ir1_o, ir2_o, ir3_o;
  logic [2:0] grp_len_o;

  typedef struct packed {
    insn_t      ir0;
    insn_t      ir1;
    insn_t      ir2;
    insn_t      ir3;
    logic [2:0] len;
  } grp_t;

  int   checks = 0;
  int   errors = 0;
  grp_t exp_q[$];
  grp_t mon_e;
  int   orphan_seen = 0;
  int   orphan_exp  = 0;

  bw_decode_window #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .fetch_idle_i  (fetch_idle_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_insn_i  (fetch_insn_i),
    .fetch_ready_o (fetch_ready_o),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .ir_o          (ir_o),
    .ir1_o         (ir1_o),
    .ir2_o         (ir2_o),
    .ir3_o         (ir3_o),
    .grp_len_o     (grp_len_o),
    .orphan_o      (orphan_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic insn_t mk(opcode_e op, logic [24:0] f);
    insn_t i;
    i.operand = f;
    i.opcode  = op;
    return i;
  endfunction

  function automatic grp_t grp(insn_t a, insn_t b, insn_t c, insn_t d, logic [2:0] len);
    grp_t g;
    g.ir0 = a; g.ir1 = b; g.ir2 = c; g.ir3 = d; g.len = len;
    return g;
  endfunction

  function automatic insn_t rand_insn();
    logic [24:0] f;
    f = 25'($urandom());
    case ($urandom_range(0, 2))
      0:       return mk(OP_ADD, f);
      1:       return mk(OP_ADDI, f);
      default: return mk(OP_LDO, f);
    endcase
  endfunction

  // Monitor: compare each group the decoder accepts against the scoreboard.
  always @(negedge clk) begin
    if (orphan_o === 1'b1) orphan_seen++;
    if (dec_valid_o === 1'b1 && dec_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_group", 64'(ir_o), 64'(NOP_INSN) ^ 64'h1);
      end else begin
        mon_e = exp_q.pop_front();
        check("grp_ir",  64'(ir_o),      64'(mon_e.ir0));
        check("grp_ir1", 64'(ir1_o),     64'(mon_e.ir1));
        check("grp_ir2", 64'(ir2_o),     64'(mon_e.ir2));
        check("grp_ir3", 64'(ir3_o),     64'(mon_e.ir3));
        check("grp_len", 64'(grp_len_o), 64'(mon_e.len));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input insn_t i);
    fetch_valid_i = 1'b1;
    fetch_insn_i  = i;
    step();
    fetch_valid_i = 1'b0;
  endtask

  // One fetch cycle with valid held; records acceptance in the scoreboard.
  task automatic drive_cycle(output bit acc);
    @(negedge clk);
    acc = fetch_ready_o;
    step();
    if (acc) begin
      exp_q.push_back(grp(fetch_insn_i, NOP_INSN, NOP_INSN, NOP_INSN, 3'd1));
      fetch_insn_i = rand_insn();
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    step();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    insn_t ldo, c1, c2, c3, c4, add, addi;
    bit    acc;
    int    sent, cyc;

    ldo  = mk(OP_LDO,  25'h0001234);
    c1   = mk(OP_CON1, 25'h0000aaa);
    c2   = mk(OP_CON2, 25'h0000bbb);
    c3   = mk(OP_CON3, 25'h0000ccc);
    c4   = mk(OP_CON4, 25'h0000ddd);
    add  = mk(OP_ADD,  25'h0000321);
    addi = mk(OP_ADDI, 25'h0000777);

    rst_i = 1'b1; flush_i = 1'b0; fetch_idle_i = 1'b1; fetch_valid_i = 1'b0;
    dec_ready_i = 1'b1; fetch_insn_i = NOP_INSN;
    step(); step();
    rst_i = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_dec_valid", 64'(dec_valid_o),   64'd0);
    check("rst_ir",        64'(ir_o),          64'(NOP_INSN));
    check("rst_ir1",       64'(ir1_o),         64'(NOP_INSN));
    check("rst_ir2",       64'(ir2_o),         64'(NOP_INSN));
    check("rst_ir3",       64'(ir3_o),         64'(NOP_INSN));
    check("rst_grp_len",   64'(grp_len_o),     64'd0);
    check("rst_orphan",    64'(orphan_o),      64'd0);
    check("rst_ready",     64'(fetch_ready_o), 64'd1);
    check("rst_count",     64'(dut.fifo_count), 64'd0);
    step();

    // Single ADDI with fetch idle: issues one edge after enqueue
    exp_q.push_back(grp(addi, NOP_INSN, NOP_INSN, NOP_INSN, 3'd1));
    push1(addi);
    @(negedge clk);
    check("single_pre_valid", 64'(dec_valid_o), 64'd0);
    step();
    @(negedge clk);
    check("single_valid", 64'(dec_valid_o),     64'd1);
    check("single_count", 64'(dut.fifo_count), 64'd0);
    step();
    wait_drain("drain_single");

    // LDO CON1 CON2 ADD streamed without idle
    fetch_idle_i = 1'b0;
    exp_q.push_back(grp(ldo, c1, c2, NOP_INSN, 3'd3));
    exp_q.push_back(grp(add, NOP_INSN, NOP_INSN, NOP_INSN, 3'd1));
    push1(ldo); push1(c1); push1(c2); push1(add);
    repeat (4) step();
    @(negedge clk);
    check("add_waits_valid", 64'(dec_valid_o),     64'd0);
    check("add_waits_count", 64'(dut.fifo_count), 64'd1);
    step();
    fetch_idle_i = 1'b1;
    wait_drain("drain_chain3");

    // Full chain of four, trailing CON4 becomes an orphan
    fetch_idle_i = 1'b0;
    exp_q.push_back(grp(ldo, c1, c2, c3, 3'd4));
    orphan_exp++;
    push1(ldo); push1(c1); push1(c2); push1(c3); push1(c4);
    repeat (4) step();
    @(negedge clk);
    check("orphan_count_empty", 64'(dut.fifo_count), 64'd0);
    step();
    wait_drain("drain_chain4");

    // LDO CON1 without idle: held until fetch goes idle
    exp_q.push_back(grp(ldo, c1, NOP_INSN, NOP_INSN, 3'd2));
    push1(ldo); push1(c1);
    repeat (4) step();
    @(negedge clk);
    check("unresolved_valid", 64'(dec_valid_o),     64'd0);
    check("unresolved_count", 64'(dut.fifo_count), 64'd2);
    step();
    fetch_idle_i = 1'b1;
    wait_drain("drain_unresolved");

    // Fill with decoder stalled, then stream 32 with push/pop overlap
    dec_ready_i   = 1'b0;
    fetch_valid_i = 1'b1;
    fetch_insn_i  = rand_insn();
    sent = 0;
    cyc  = 0;
    do begin
      drive_cycle(acc);
      if (acc) sent++;
      cyc++;
    end while (acc && cyc < 40);
    @(negedge clk);
    check("full_ready",  64'(fetch_ready_o),   64'd0);
    check("full_count",  64'(dut.fifo_count), 64'(DEPTH));
    check("full_valid",  64'(dec_valid_o),     64'd1);
    check("full_sent",   64'(sent),            64'(DEPTH + 1));
    step();
    dec_ready_i = 1'b1;
    cyc = 0;
    while (sent < 32 && cyc < 200) begin
      drive_cycle(acc);
      if (acc) sent++;
      cyc++;
    end
    fetch_valid_i = 1'b0;
    check("stream_sent", 64'(sent), 64'd32);
    wait_drain("drain_stream");

    // Flush while a group is presented and five entries are buffered
    dec_ready_i = 1'b0;
    repeat (6) push1(rand_insn());
    @(negedge clk);
    check("preflush_count", 64'(dut.fifo_count), 64'd5);
    check("preflush_valid", 64'(dec_valid_o),     64'd1);
    flush_i       = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_insn_i  = add;
    step();
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    @(negedge clk);
    check("flush_valid", 64'(dec_valid_o),     64'd0);
    check("flush_count", 64'(dut.fifo_count), 64'd0);
    check("flush_ready", 64'(fetch_ready_o),   64'd1);
    step();
    dec_ready_i = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check("flush_drop_valid", 64'(dec_valid_o), 64'd0);
    step();
    exp_q.push_back(grp(addi, NOP_INSN, NOP_INSN, NOP_INSN, 3'd1));
    push1(addi);
    wait_drain("drain_post_flush");

    check("orphan_pulses", 64'(orphan_seen), 64'(orphan_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
